// File: rtl/alu_control_muldiv.sv
// ALU select decode plus an iterative multiply/divide engine with HI/LO registers.
// The engine stalls HI/LO-class instructions while it is busy.
module alu_control_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             start,
  input  logic             kill,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [4:0]       alu_sel,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [4:0] SEL_AND  = 5'b00000;
  localparam logic [4:0] SEL_OR   = 5'b00001;
  localparam logic [4:0] SEL_ADD  = 5'b00010;
  localparam logic [4:0] SEL_XOR  = 5'b00100;
  localparam logic [4:0] SEL_NOR  = 5'b00101;
  localparam logic [4:0] SEL_SUB  = 5'b00110;
  localparam logic [4:0] SEL_SLT  = 5'b00111;
  localparam logic [4:0] SEL_SLL  = 5'b01000;
  localparam logic [4:0] SEL_SRL  = 5'b01001;
  localparam logic [4:0] SEL_SRA  = 5'b01010;
  localparam logic [4:0] SEL_SLTU = 5'b01011;
  localparam logic [4:0] SEL_NONE = 5'b11111;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;
  logic                 neg_lo_q;
  logic                 neg_hi_q;
  logic                 is_div_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 done_q;

  // ---------------- ALU select decode ----------------
  always_comb begin
    alu_sel = SEL_ADD;
    unique case (alu_op)
      4'b0000: alu_sel = SEL_ADD;
      4'b0001: alu_sel = SEL_SUB;
      4'b0010: begin
        unique case (funct)
          6'h20, 6'h21: alu_sel = SEL_ADD;
          6'h22, 6'h23: alu_sel = SEL_SUB;
          6'h24:        alu_sel = SEL_AND;
          6'h25:        alu_sel = SEL_OR;
          6'h26:        alu_sel = SEL_XOR;
          6'h27:        alu_sel = SEL_NOR;
          6'h2A:        alu_sel = SEL_SLT;
          6'h2B:        alu_sel = SEL_SLTU;
          6'h00, 6'h04: alu_sel = SEL_SLL;
          6'h02, 6'h06: alu_sel = SEL_SRL;
          6'h03, 6'h07: alu_sel = SEL_SRA;
          default:      alu_sel = SEL_NONE;
        endcase
      end
      4'b0011: alu_sel = SEL_AND;
      4'b0100: alu_sel = SEL_OR;
      4'b0101: alu_sel = SEL_SLT;
      4'b0110: alu_sel = SEL_XOR;
      4'b0111: alu_sel = SEL_SLTU;
      default: alu_sel = SEL_ADD;
    endcase
  end

  // ---------------- HI/LO command qualification ----------------
  logic is_hilo_funct;
  logic hilo_cmd;
  logic accept;

  // 0x10-0x13 and 0x18-0x1B
  assign is_hilo_funct = (funct[5:2] == 4'b0100) || (funct[5:2] == 4'b0110);
  assign hilo_cmd      = start && (alu_op == 4'b0010) && is_hilo_funct;
  assign busy          = (state_q != IDLE);
  assign stall         = hilo_cmd && busy;
  assign accept        = hilo_cmd && !busy && !kill;

  // ---------------- operand preparation ----------------
  logic             op_is_div;
  logic             op_signed;
  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_abs;
  logic [WIDTH-1:0] rt_abs;

  assign op_is_div = (funct == F_DIV) || (funct == F_DIVU);
  // A zero divisor runs unsigned so the remainder comes out as the raw dividend.
  assign op_signed = !funct[0] && !(op_is_div && (rt_val == '0));
  assign rs_neg    = op_signed && rs_val[WIDTH-1];
  assign rt_neg    = op_signed && rt_val[WIDTH-1];
  assign rs_abs    = rs_neg ? (~rs_val + 1'b1) : rs_val;
  assign rt_abs    = rt_neg ? (~rt_val + 1'b1) : rt_val;

  // ---------------- iteration datapath ----------------
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step_d;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     rem_diff;
  logic                 rem_ge;
  logic [WIDTH-1:0]     rem_new;
  logic [2*WIDTH-1:0]   div_step_d;

  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_step_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

  assign rem_sh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge     = (rem_sh >= {1'b0, opnd_q});
  assign rem_diff   = rem_sh[WIDTH-1:0] - opnd_q;
  assign rem_new    = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
  assign div_step_d = {rem_new, acc_q[WIDTH-2:0], rem_ge};

  // ---------------- sign fix-up ----------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;

  assign prod_fix = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  assign hi_d     = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_d     = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

  // ---------------- FSM and HI/LO state ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (kill && busy) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (accept) begin
              unique case (funct)
                F_MTHI: hi_q <= rs_val;
                F_MTLO: lo_q <= rs_val;
                F_MULT, F_MULTU: begin
                  state_q  <= MUL;
                  cnt_q    <= CW'(WIDTH);
                  acc_q    <= {{WIDTH{1'b0}}, rt_abs};
                  opnd_q   <= rs_abs;
                  neg_lo_q <= rs_neg ^ rt_neg;
                  neg_hi_q <= rs_neg ^ rt_neg;
                  is_div_q <= 1'b0;
                end
                F_DIV, F_DIVU: begin
                  state_q  <= DIV;
                  cnt_q    <= CW'(WIDTH);
                  acc_q    <= {{WIDTH{1'b0}}, rs_abs};
                  opnd_q   <= rt_abs;
                  neg_lo_q <= rs_neg ^ rt_neg;
                  neg_hi_q <= rs_neg;
                  is_div_q <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          MUL: begin
            acc_q <= mul_step_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_q <= FIX;
          end
          DIV: begin
            acc_q <= div_step_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_q <= FIX;
          end
          FIX: begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign hi         = hi_q;
  assign lo         = lo_q;
  assign done       = done_q;
  assign hilo_rdata = (funct == F_MFLO) ? lo_q : hi_q;

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Directed bench for alu_control_muldiv (WIDTH=32): decode, mul/div results, stalls, kill, reset.
module tb_alu_control_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   alu_op = 4'b0;
  logic [5:0]   funct = 6'h20;
  logic         start = 1'b0;
  logic         kill = 1'b0;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic [4:0]   alu_sel;
  logic [W-1:0] hilo_rdata;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int errors = 0;
  int checks = 0;

  alu_control_muldiv #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_op     (alu_op),
    .funct      (funct),
    .start      (start),
    .kill       (kill),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .alu_sel    (alu_sel),
    .hilo_rdata (hilo_rdata),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  // Issues one HI/LO-class op and waits (bounded) until busy drops; returns busy cycle count.
  task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int cycles);
    @(negedge clk);
    alu_op = 4'b0010; funct = f; rs_val = a; rt_val = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; funct = 6'h20;
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    $display("op funct=%h rs=%h rt=%h -> hi=%h lo=%h busy_cycles=%0d", f, a, b, hi, lo, cycles);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_decode();
    logic [3:0] ops [15];
    logic [5:0] fns [15];
    logic [4:0] exp [15];
    ops = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h7, 4'hF, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h1, 4'h2, 4'h6};
    fns = '{6'h03, 6'h07, 6'h2B, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h04, 6'h02, 6'h06, 6'h27, 6'h18, 6'h00, 6'h21, 6'h00};
    exp = '{5'b01010, 5'b01010, 5'b01011, 5'b11111, 5'b01011, 5'b00010, 5'b01000, 5'b01000,
            5'b01001, 5'b01001, 5'b00101, 5'b11111, 5'b00110, 5'b00010, 5'b00100};
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      start = 1'b0; alu_op = ops[i]; funct = fns[i];
      #1;
      $display("decode alu_op=%b funct=%h -> alu_sel=%b", ops[i], fns[i], alu_sel);
      checks++;
      if (alu_sel !== exp[i]) begin
        errors++;
        $display("FAIL decode_%0d: alu_op=%b funct=%h got %b expected %b", i, ops[i], fns[i], alu_sel, exp[i]);
      end
    end
  endtask

  task automatic test_mult();
    int cyc;
    do_op(6'h18, 32'hFFFFFFFD, 32'h7, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL mult_latency: got %0d expected 33", cyc); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done: got %b expected 1", done); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected %h", hi, 32'hFFFFFFFF); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo: got %h expected %h", lo, 32'hFFFFFFEB); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_multu();
    int cyc;
    do_op(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected %h", hi, 32'hFFFFFFFE); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected %h", lo, 32'h1); end
  endtask

  task automatic test_div();
    int cyc;
    do_op(6'h1A, 32'hFFFFFFF9, 32'h2, cyc);
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected %h", lo, 32'hFFFFFFFD); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected %h", hi, 32'hFFFFFFFF); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", cyc); end
  endtask

  task automatic test_div_zero();
    int cyc;
    do_op(6'h1B, 32'd100, 32'h0, cyc);
    checks++; if (hi !== 32'h00000064) begin errors++; $display("FAIL divu0_hi: got %h expected %h", hi, 32'h64); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_lo: got %h expected %h", lo, 32'hFFFFFFFF); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL divu0_latency: got %0d expected 33", cyc); end
    do_op(6'h1A, 32'hFFFFFFF9, 32'h0, cyc);
    checks++; if (hi !== 32'hFFFFFFF9) begin errors++; $display("FAIL div0_hi: got %h expected %h", hi, 32'hFFFFFFF9); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo: got %h expected %h", lo, 32'hFFFFFFFF); end
  endtask

  task automatic test_div_min();
    int cyc;
    do_op(6'h1A, 32'h80000000, 32'hFFFFFFFF, cyc);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL divmin_lo: got %h expected %h", lo, 32'h80000000); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divmin_hi: got %h expected %h", hi, 32'h0); end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    alu_op = 4'b0010; funct = 6'h13; rs_val = 32'h1234; start = 1'b1;
    @(negedge clk);
    checks++; if (lo !== 32'h1234) begin errors++; $display("FAIL mtlo_lo: got %h expected %h", lo, 32'h1234); end
    funct = 6'h11; rs_val = 32'h5678;
    @(negedge clk);
    start = 1'b0; funct = 6'h20;
    $display("mtlo/mthi -> hi=%h lo=%h", hi, lo);
    checks++; if (hi !== 32'h5678) begin errors++; $display("FAIL mthi_hi: got %h expected %h", hi, 32'h5678); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mt_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mt_done: got %b expected 0", done); end
  endtask

  task automatic test_stall();
    int cyc;
    @(negedge clk);
    alu_op = 4'b0010; funct = 6'h18; rs_val = 32'd2; rt_val = 32'd3; start = 1'b1;
    @(negedge clk);
    funct = 6'h12;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_mflo: got %b expected 1", stall); end
    checks++; if (hilo_rdata !== 32'h1234) begin errors++; $display("FAIL stall_rdata: got %h expected %h", hilo_rdata, 32'h1234); end
    @(negedge clk);
    funct = 6'h20;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_add: got %b expected 0", stall); end
    checks++; if (alu_sel !== 5'b00010) begin errors++; $display("FAIL stall_add_sel: got %b expected 00010", alu_sel); end
    @(negedge clk);
    funct = 6'h13; rs_val = 32'hDEAD;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_mtlo: got %b expected 1", stall); end
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_release: got %b expected 0", stall); end
    start = 1'b0; funct = 6'h20;
    $display("stalled mult 2*3 -> hi=%h lo=%h done=%b", hi, lo, done);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", done); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL stall_lo: got %h expected %h", lo, 32'd6); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL stall_hi: got %h expected %h", hi, 32'd0); end
  endtask

  task automatic test_kill();
    int seen_done;
    @(negedge clk);
    alu_op = 4'b0010; funct = 6'h11; rs_val = 32'hAAAA; start = 1'b1;
    @(negedge clk);
    funct = 6'h13; rs_val = 32'hBBBB;
    @(negedge clk);
    funct = 6'h18; rs_val = 32'd5; rt_val = 32'd6;
    @(negedge clk);
    start = 1'b0; funct = 6'h20;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    $display("kill mid-mult -> busy=%b hi=%h lo=%h", busy, hi, lo);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'hAAAA) begin errors++; $display("FAIL kill_hi: got %h expected %h", hi, 32'hAAAA); end
    checks++; if (lo !== 32'hBBBB) begin errors++; $display("FAIL kill_lo: got %h expected %h", lo, 32'hBBBB); end
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen_done++;
      @(negedge clk);
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL kill_no_done: got %0d done pulses expected 0", seen_done); end
  endtask

  task automatic test_kill_start();
    @(negedge clk);
    alu_op = 4'b0010; funct = 6'h19; rs_val = 32'd9; rt_val = 32'd9; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0; funct = 6'h20;
    $display("kill+start -> busy=%b", busy);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL killstart_busy: got %b expected 0", busy); end
    repeat (40) @(negedge clk);
    checks++; if (lo !== 32'hBBBB) begin errors++; $display("FAIL killstart_lo: got %h expected %h", lo, 32'hBBBB); end
  endtask

  task automatic test_async_reset();
    int cyc;
    @(negedge clk);
    alu_op = 4'b0010; funct = 6'h1B; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; funct = 6'h20;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset mid-divide -> busy=%b hi=%h lo=%h", busy, hi, lo);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL areset_hi: got %h expected %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL areset_lo: got %h expected %h", lo, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(6'h1B, 32'd100, 32'd7, cyc);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL rerun_lo: got %h expected %h", lo, 32'd14); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL rerun_hi: got %h expected %h", hi, 32'd2); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL rerun_latency: got %0d expected 33", cyc); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_div_min();
    test_mthi_mtlo();
    test_stall();
    test_kill();
    test_kill_start();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
